// File: rtl/t03_player_motion.sv
// Player motion controller: walk, jump arc, and attack sequencing.
// All state advances on frame ticks and holds while frozen.
module t03_player_motion #(
    parameter int X_INIT         = 100,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 600,
    parameter int WALK_STEP      = 4,
    parameter int JUMP_V         = 20,
    parameter int GRAVITY        = 1,
    parameter int ATTACK_FRAMES  = 8,
    parameter bit FACE_LEFT_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        freeze,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    input  logic        btn_attack,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [1:0]  p_state,
    output logic        p_left,
    output logic        airborne
);

    // state  | meaning
    // IDLE   | grounded, no horizontal input
    // WALK   | grounded, moving in one direction
    // JUMP   | airborne, integrating vy into y each frame
    // ATTACK | position frozen, counting down the attack frames
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WALK   = 2'b01,
        S_JUMP   = 2'b10,
        S_ATTACK = 2'b11
    } state_t;

    localparam logic signed [12:0] X_MIN_S  = 13'(X_MIN);
    localparam logic signed [12:0] X_MAX_S  = 13'(X_MAX);
    localparam logic signed [12:0] STEP_S   = 13'(WALK_STEP);
    localparam logic signed [7:0]  JUMP_V_S = 8'(JUMP_V);
    localparam logic signed [7:0]  GRAV_S   = 8'(GRAVITY);
    localparam logic [7:0]         ATK_LOAD = 8'(ATTACK_FRAMES - 1);
    localparam logic [10:0]        X_INIT_U = 11'(X_INIT);

    state_t             state, state_nx;
    logic signed [7:0]  vy, vy_nx, vy_src;
    logic [7:0]         atk_cnt, atk_cnt_nx;
    logic [10:0]        x_nx, y_nx, x_moved;
    logic               p_left_nx, airborne_nx;
    logic               tick, dir_left, dir_right, dir_one, do_phys;
    logic signed [12:0] x_try;
    logic signed [11:0] y_sum;

    assign tick      = frame_tick & ~freeze;
    // Both directions held cancel out, as does neither.
    assign dir_left  = btn_left & ~btn_right;
    assign dir_right = btn_right & ~btn_left;
    assign dir_one   = dir_left | dir_right;
    assign p_state   = state;

    // Candidate x after one walk step, clamped to the playfield.
    always_comb begin
        x_try = $signed({2'b00, x});
        if (dir_left) begin
            x_try = x_try - STEP_S;
        end else if (dir_right) begin
            x_try = x_try + STEP_S;
        end
        if (x_try < X_MIN_S) begin
            x_moved = X_MIN_S[10:0];
        end else if (x_try > X_MAX_S) begin
            x_moved = X_MAX_S[10:0];
        end else begin
            x_moved = x_try[10:0];
        end
    end

    // Next-state, motion and attack counter for one frame tick.
    always_comb begin
        state_nx   = state;
        x_nx       = x;
        y_nx       = y;
        vy_nx      = vy;
        atk_cnt_nx = atk_cnt;
        p_left_nx  = p_left;
        vy_src     = vy;
        do_phys    = 1'b0;
        y_sum      = '0;

        case (state)
            S_IDLE, S_WALK: begin
                x_nx = x_moved;
                if (dir_one) begin
                    p_left_nx = dir_left;
                end
                if (btn_attack) begin
                    state_nx   = S_ATTACK;
                    atk_cnt_nx = ATK_LOAD;
                end else if (btn_jump) begin
                    // Launch frame already integrates the launch velocity.
                    vy_src  = JUMP_V_S;
                    do_phys = 1'b1;
                end else if (dir_one) begin
                    state_nx = S_WALK;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_JUMP: begin
                x_nx = x_moved;
                if (dir_one) begin
                    p_left_nx = dir_left;
                end
                do_phys = 1'b1;
            end
            S_ATTACK: begin
                if (atk_cnt == 8'd0) begin
                    state_nx = S_IDLE;
                end else begin
                    atk_cnt_nx = atk_cnt - 8'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (do_phys) begin
            y_sum = $signed({1'b0, y}) + {{4{vy_src[7]}}, vy_src};
            if (y_sum > 12'sd0) begin
                state_nx = S_JUMP;
                y_nx     = y_sum[10:0];
                vy_nx    = vy_src - GRAV_S;
            end else begin
                y_nx     = '0;
                vy_nx    = '0;
                state_nx = dir_one ? S_WALK : S_IDLE;
            end
        end

        airborne_nx = (y_nx != 11'd0) || (state_nx == S_JUMP);
    end

    // State register; every output comes straight from here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            x        <= X_INIT_U;
            y        <= '0;
            vy       <= '0;
            atk_cnt  <= '0;
            p_left   <= FACE_LEFT_INIT;
            airborne <= 1'b0;
        end else if (tick) begin
            state    <= state_nx;
            x        <= x_nx;
            y        <= y_nx;
            vy       <= vy_nx;
            atk_cnt  <= atk_cnt_nx;
            p_left   <= p_left_nx;
            airborne <= airborne_nx;
        end
    end

endmodule

// File: doc/t03_player_motion.md
T03_PLAYER_MOTION -- requirements
Module: t03_player_motion

Interface
REQ-001 SHALL have parameters (name, default, meaning): X_INIT 100 spawn x; X_MIN 0 left bound; X_MAX 600 right bound; WALK_STEP 4 px per frame; JUMP_V 20 launch velocity; GRAVITY 1 velocity decrement per frame; ATTACK_FRAMES 8 attack duration; FACE_LEFT_INIT 0 initial facing.
REQ-002 SHALL have these ports (name, direction, width, meaning):
 clk  in  1  system clock, single domain
 rst  in  1  asynchronous, active-high reset
 frame_tick  in  1  one-cycle pulse, once per video frame
 freeze  in  1  1 = game not in play; hold all state
 btn_left  in  1  level, move left
 btn_right  in  1  level, move right
 btn_jump  in  1  level, jump request
 btn_attack  in  1  level, attack request
 x  out  11  horizontal position, unsigned
 y  out  11  height above ground, 0 = grounded; the display stage draws at 500 - y
 p_state  out  2  00 idle, 01 walk, 10 jump, 11 attack
 p_left  out  1  1 = facing left
 airborne  out  1  1 when y != 0 or the state is JUMP

Function
REQ-003 SHALL update state, x, y, vy and the attack counter only on clk edges where frame_tick=1 and freeze=0; on all other edges all registers SHALL hold.
REQ-004 SHALL drive every output from a register, with no combinational path from inputs to outputs; an update is visible one clk after the sampling tick.
REQ-005 SHALL implement a 4-state FSM:
 IDLE (p_state 00)
 WALK (01)
 JUMP (10)
 ATTACK (11)
REQ-006 SHALL apply this priority at a tick in IDLE or WALK: btn_attack -> ATTACK (counter = ATTACK_FRAMES-1); else btn_jump -> JUMP (vy = JUMP_V); else exactly one of left/right -> WALK; else IDLE.
REQ-007 SHALL treat btn_left and btn_right both high as no horizontal input; x and p_left are unchanged.
REQ-008 In IDLE, WALK and JUMP, with exactly one direction held, a tick SHALL change x by WALK_STEP in that direction, clamp the result to [X_MIN, X_MAX], and set p_left to the direction held (1 = left).
REQ-009 SHALL hold vy as a signed 8-bit register; in JUMP each tick SHALL compute y_next = y + vy in at least 12-bit signed arithmetic.
REQ-010 If y_next > 0, the tick SHALL set y = y_next and vy = vy - GRAVITY.
REQ-011 If y_next <= 0, the tick SHALL set y = 0 and vy = 0, and the state SHALL become WALK if exactly one direction is held, else IDLE; jump/attack inputs SHALL be ignored on the landing tick.
REQ-012 In ATTACK, x, y and p_left SHALL hold; each tick SHALL decrement the counter, and the tick on which the counter is 0 SHALL return the FSM to IDLE.
REQ-013 SHALL ignore btn_jump and btn_attack while airborne (no double jump, no air attack).
REQ-014 Held buttons SHALL retrigger: btn_jump held at the landing-following tick SHALL start a new jump; btn_attack held at ATTACK exit SHALL start a new attack on the next tick.
REQ-015 Asserting freeze mid-jump or mid-attack SHALL hold position, velocity and counter exactly; deasserting it SHALL resume from the held values.

Reset
REQ-016 While rst=1, regardless of clk: x = X_INIT, y = 0, vy = 0, counter = 0, FSM = IDLE, p_state = 00, p_left = FACE_LEFT_INIT, airborne = 0.
REQ-017 Reset asserted mid-jump or mid-attack SHALL abort the motion; the first tick after release SHALL behave as from IDLE at X_INIT.

Verification
REQ-018 Walk test: defaults, btn_right held for 5 ticks -> x = 120, p_state = 01, p_left = 0; release, 1 tick -> p_state = 00, x = 120.
REQ-019 Jump arc test: btn_jump for 1 tick at ground -> y = 20 after tick 1, peak y = 210 at ticks 20-21, y = 0 and p_state = 00 after tick 41; airborne = 1 throughout.
REQ-020 Clamp and conflict test: x = 598 with btn_right -> 600, held 3 more ticks -> stays 600; both directions held -> x and p_left unchanged.
REQ-021 Attack test: btn_attack and btn_jump together at ground -> p_state = 11 for exactly 8 ticks with x/y frozen, then 00; btn_attack pressed mid-jump -> ignored.
REQ-022 Freeze and reset test: freeze at jump tick 10 (y = 155) held for 50 ticks -> y stays 155, then resumes the arc; rst pulsed mid-jump -> x = 100, y = 0, p_state = 00 immediately, without waiting for a clk edge.
